cronometro_ctrl: RTL and testbench

Control sequencer for the 9-digit stopwatch counter. Conditions the raw play, stop and lap buttons and runs the run/pause/lap/clear state machine. Generates the 1 ms count-enable tick and clear pulse that drive the digit counter datapath, plus the display-freeze flag used by the display multiplexer.

---
 rtl/cronometro_ctrl_if.sv | 22 ++
 rtl/cronometro_ctrl.sv | 136 +++++++++++++
 tb/tb_cronometro_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cronometro_ctrl_if.sv
// Button and control bundle for the stopwatch sequencer.
// The master drives the raw buttons; the slave returns the datapath controls.
interface cronometro_ctrl_if;
  logic       play;
  logic       stop;
  logic       lap;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_freeze;
  logic       running;
  logic [1:0] state;

  modport master (
    output play, stop, lap,
    input  cnt_en, cnt_clr, disp_freeze, running, state
  );

  modport slave (
    input  play, stop, lap,
    output cnt_en, cnt_clr, disp_freeze, running, state
  );
endinterface

// File: rtl/cronometro_ctrl.sv
// Stopwatch control sequencer: button conditioning, run/pause/lap/clear FSM,
// millisecond tick prescaler and display-freeze flag.
module cronometro_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  cronometro_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // Button bit order everywhere: [0]=play, [1]=stop, [2]=lap.
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_prev;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  logic          play_p;
  logic          stop_p;
  logic          lap_p;

  state_t        cur_state;
  state_t        nxt_state;
  logic          cur_running;
  logic          nxt_running;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;

  assign raw = {bus.lap, bus.stop, bus.play};
  assign {lap_p, stop_p, play_p} = press;

  // Synchronize, debounce and edge-detect the three buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 3'b000;
      sync2    <= 3'b000;
      deb      <= 3'b000;
      deb_prev <= 3'b000;
      press    <= 3'b000;
      for (int b = 0; b < 3; b++) begin
        deb_cnt[b] <= '0;
      end
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      press    <= deb & ~deb_prev;
      for (int b = 0; b < 3; b++) begin
        if (sync2[b] == deb[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_MAX) begin
          deb[b]     <= sync2[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DW'(1);
        end
      end
    end
  end

  // Next-state decode; stop outranks play, which outranks lap.
  always_comb begin
    nxt_state = cur_state;
    if (stop_p) begin
      nxt_state = IDLE;
    end else if (play_p) begin
      case (cur_state)
        IDLE:    nxt_state = RUN;
        RUN:     nxt_state = PAUSE;
        PAUSE:   nxt_state = RUN;
        LAP:     nxt_state = PAUSE;
        default: nxt_state = IDLE;
      endcase
    end else if (lap_p) begin
      case (cur_state)
        RUN:     nxt_state = LAP;
        LAP:     nxt_state = RUN;
        default: nxt_state = cur_state;
      endcase
    end else begin
      nxt_state = cur_state;
    end
  end

  assign cur_running = (cur_state == RUN) || (cur_state == LAP);
  assign nxt_running = (nxt_state == RUN) || (nxt_state == LAP);

  // Prescaler keeps its partial count across PAUSE and restarts from IDLE.
  always_comb begin
    presc_nxt = presc;
    if ((cur_state == IDLE) || (nxt_state == IDLE)) begin
      presc_nxt = '0;
    end else if (cur_running) begin
      presc_nxt = (presc == PRESC_MAX) ? '0 : presc + PW'(1);
    end else begin
      presc_nxt = presc;
    end
  end

  // State, prescaler and registered datapath controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state       <= IDLE;
      presc           <= '0;
      bus.cnt_en      <= 1'b0;
      bus.cnt_clr     <= 1'b0;
      bus.disp_freeze <= 1'b0;
      bus.running     <= 1'b0;
    end else begin
      cur_state       <= nxt_state;
      presc           <= presc_nxt;
      bus.cnt_en      <= nxt_running && (presc_nxt == PRESC_MAX);
      bus.cnt_clr     <= stop_p;
      bus.disp_freeze <= (nxt_state == LAP);
      bus.running     <= nxt_running;
    end
  end

  assign bus.state = cur_state;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed and randomized bench for cronometro_ctrl against a cycle-level
// behavioural model of the button pipeline, FSM rules and tick cadence.
module tb_cronometro_ctrl;
  localparam int TICK = 4;
  localparam int DEB  = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic clk = 1'b0;
  logic rst;
  cronometro_ctrl_if bus ();

  cronometro_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int en_seen  = 0;
  int clr_seen = 0;

  // Model: raw sample history, accepted levels, press pulses, mode and tick phase.
  logic [31:0] m_hist [3];
  bit          m_deb   [3];
  bit          m_rose  [3];
  bit          m_pulse [3];
  int          m_mode;
  int          m_phase;
  bit          m_clr;
  bit          m_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_hist[b]  = 32'd0;
      m_deb[b]   = 1'b0;
      m_rose[b]  = 1'b0;
      m_pulse[b] = 1'b0;
    end
    m_mode  = M_IDLE;
    m_phase = 0;
    m_clr   = 1'b0;
    m_en    = 1'b0;
  endtask

  task automatic model_edge(input bit p, input bit s, input bit l);
    bit [2:0] r;
    int old_mode;
    bit flip;
    r        = {l, s, p};
    old_mode = m_mode;
    m_clr    = 1'b0;
    if (m_pulse[1]) begin
      m_mode = M_IDLE;
      m_clr  = 1'b1;
    end else if (m_pulse[0]) begin
      m_mode = (old_mode == M_RUN || old_mode == M_LAP) ? M_PAUSE : M_RUN;
    end else if (m_pulse[2]) begin
      if (old_mode == M_RUN) m_mode = M_LAP;
      else if (old_mode == M_LAP) m_mode = M_RUN;
    end
    if (old_mode == M_IDLE || m_mode == M_IDLE) m_phase = 0;
    else if (old_mode == M_RUN || old_mode == M_LAP) m_phase = (m_phase + 1) % TICK;
    m_en = (m_mode == M_RUN || m_mode == M_LAP) && (m_phase == TICK - 1);
    // A level is accepted once DEB+1 consecutive synchronized samples disagree with it.
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][30:0], r[b]};
      flip = 1'b1;
      for (int j = 2; j <= 2 + DEB; j++) begin
        if (m_hist[b][j] == m_deb[b]) flip = 1'b0;
      end
      m_pulse[b] = m_rose[b];
      m_rose[b]  = 1'b0;
      if (flip) begin
        m_deb[b]  = ~m_deb[b];
        m_rose[b] = m_deb[b];
      end
    end
  endtask

  task automatic step(input bit p, input bit s, input bit l);
    bus.play = p;
    bus.stop = s;
    bus.lap  = l;
    @(posedge clk);
    model_edge(p, s, l);
    #1;
    check("state",       bus.state,       m_mode);
    check("cnt_en",      bus.cnt_en,      m_en);
    check("cnt_clr",     bus.cnt_clr,     m_clr);
    check("disp_freeze", bus.disp_freeze, (m_mode == M_LAP));
    check("running",     bus.running,     (m_mode == M_RUN || m_mode == M_LAP));
    if (bus.cnt_en === 1'b1) en_seen++;
    if (bus.cnt_clr === 1'b1) clr_seen++;
  endtask

  task automatic drive(input bit p, input bit s, input bit l, input int n);
    repeat (n) step(p, s, l);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   bus.state,       2'b00);
    check({tag, "_cnt_en"},  bus.cnt_en,      1'b0);
    check({tag, "_cnt_clr"}, bus.cnt_clr,     1'b0);
    check({tag, "_freeze"},  bus.disp_freeze, 1'b0);
    check({tag, "_running"}, bus.running,     1'b0);
  endtask

  initial begin : main
    int  left [3];
    bit  lvl  [3];
    int  guard;

    bus.play = 1'b0;
    bus.stop = 1'b0;
    bus.lap  = 1'b0;
    rst      = 1'b1;
    model_reset();
    #12;
    check_reset_outputs("por");
    rst = 1'b0;

    // Bounce: 2 high, 2 low, 2 high never reaches DEB+1 stable samples.
    drive(1'b1, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 1'b0, 2);
    drive(1'b0, 1'b0, 1'b0, 10);
    check("bounce_state", bus.state, 2'b00);

    // Play: RUN from the 8th edge, ticks on RUN cycles 4, 8, 12, 16.
    en_seen  = 0;
    clr_seen = 0;
    drive(1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 20);
    check("run_state", bus.state, 2'b01);
    check("run_ticks", en_seen, 4);
    check("run_noclr", clr_seen, 0);

    // Pause with saved phase 2, then resume: tick on 2nd RUN cycle.
    drive(1'b0, 1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 4);
    check("pause_state", bus.state, 2'b10);
    en_seen = 0;
    drive(1'b0, 1'b0, 1'b0, 20);
    check("pause_noticks", en_seen, 0);
    drive(1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0);
    check("resume_state", bus.state, 2'b01);
    check("resume_c1", bus.cnt_en, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("resume_c2", bus.cnt_en, 1'b1);

    // Lap: freeze while ticks continue, then coincident play+stop clears.
    drive(1'b0, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b1, 4);
    drive(1'b0, 1'b0, 1'b0, 4);
    check("lap_state", bus.state, 2'b11);
    en_seen = 0;
    drive(1'b0, 1'b0, 1'b0, 12);
    check("lap_ticks", en_seen, 3);
    check("lap_freeze", bus.disp_freeze, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 3);
    clr_seen = 0;
    step(1'b0, 1'b0, 1'b0);
    check("clr_state", bus.state, 2'b00);
    check("clr_pulse", bus.cnt_clr, 1'b1);
    check("clr_freeze", bus.disp_freeze, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8);
    check("clr_once", clr_seen, 1);

    // Reset mid-RUN after five ticks, then restart from phase 0.
    drive(1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 3);
    en_seen  = 0;
    clr_seen = 0;
    guard    = 0;
    while (en_seen < 5 && guard < 40) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("five_ticks", en_seen, 5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("held");
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4);
    drive(1'b0, 1'b0, 1'b0, 3);
    check("rerun_noclr", clr_seen, 0);
    en_seen = 0;
    drive(1'b0, 1'b0, 1'b0, 3);
    check("rerun_c3", en_seen, 0);
    step(1'b0, 1'b0, 1'b0);
    check("rerun_c4", bus.cnt_en, 1'b1);

    // Random button levels held for random durations.
    for (int b = 0; b < 3; b++) begin
      left[b] = 0;
      lvl[b]  = 1'b0;
    end
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = (b == 1) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
          left[b] = $urandom_range(1, 10);
        end
        left[b]--;
      end
      step(lvl[0], lvl[1], lvl[2]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
